// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO and send/done handshake controller placed in
// front of a UART transmitter. Bytes are accepted at any rate, then handed
// to the transmitter one at a time with tx_data held for the whole frame.
module uart_tx_feeder #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  tx_send,
   output logic [7:0]            tx_data,
   input  logic                  tx_done,
   output logic                  busy
);

   localparam int                  DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] CNT_ONE  = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      SEND    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic                    tx_send_q, tx_send_d;
   logic [7:0]              tx_data_q, tx_data_d;
   logic                    overflow_q, overflow_d;
   logic [7:0]              mem [DEPTH];

   logic                    wr_acc;
   logic                    pop;

   // Flags come straight from the registered count so they are glitch-free.
   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign overflow = overflow_q;
   assign tx_send  = tx_send_q;
   assign tx_data  = tx_data_q;
   assign busy     = (state_q != IDLE) | ~empty;

   // A write is judged on the current count only: a pop in the same cycle
   // does not make room for it.
   assign wr_acc = wr_en & ~full;
   assign pop    = (state_q == LOAD);

   // Storage array; no reset needed since count gates every read.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr_q] <= wr_data;
   end

   // Pointer, count and output data next-state.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      tx_data_d  = tx_data_q;
      overflow_d = wr_en & full;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop) begin
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
         tx_data_d = mem[rd_ptr_q];
      end
      case ({wr_acc, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Handshake FSM: only leaves IDLE once the transmitter has dropped done,
   // and waits for done to fall again before considering the next byte.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!empty && !tx_done) state_d = LOAD;
         LOAD:    state_d = SEND;
         SEND:    if (tx_done) state_d = RELEASE;
         RELEASE: if (!tx_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      tx_send_d = (state_d == SEND);
   end

   // State register with asynchronous reset that drops all queued bytes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tx_send_q  <= 1'b0;
         tx_data_q  <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tx_send_q  <= tx_send_d;
         tx_data_q  <= tx_data_d;
         overflow_q <= overflow_d;
      end
   end

endmodule
